// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// Memory-mapped SPI master with a four-register CPU interface and a
// three-state shift engine (IDLE / LEAD half-bit / TRAIL half-bit).
//
// Ports
//   clk        CPU clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   cs         chip select from the address decoder
//   we         write strobe (write happens on a clk edge with cs=1, we=1)
//   addr       register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV
//   wr_data    write data
//   rd_data    combinational read data, 8'h00 when cs=0
//   irq_n      active-low interrupt, ~(ie & done)
//   spi_sck    SPI clock
//   spi_mosi   SPI data out
//   spi_cs_n   SPI slave select, software controlled via CTRL.ss
//   spi_miso   SPI data in
//
// Register map
//   DATA   write: transmit byte, read: last received byte
//   STATUS {busy, done, ovr, 5'b0}; done/ovr are write-1-to-clear
//   CTRL   {ie, 4'b0, cpha, cpol, ss}
//   DIV    SCK half-period minus one, in clk cycles
// ---------------------------------------------------------------------------
module spi_master #(
    parameter logic [7:0] DIV_RESET     = 8'd3,
    parameter int         BUS_ADDR_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     we,
    input  logic [BUS_ADDR_BITS-1:0] addr,
    input  logic [7:0]               wr_data,
    output logic [7:0]               rd_data,
    output logic                     irq_n,
    output logic                     spi_sck,
    output logic                     spi_mosi,
    output logic                     spi_cs_n,
    input  logic                     spi_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        TRAIL = 2'd2
    } state_t;

    localparam logic [BUS_ADDR_BITS-1:0] ADDR_DATA   = BUS_ADDR_BITS'(0);
    localparam logic [BUS_ADDR_BITS-1:0] ADDR_STATUS = BUS_ADDR_BITS'(1);
    localparam logic [BUS_ADDR_BITS-1:0] ADDR_CTRL   = BUS_ADDR_BITS'(2);
    localparam logic [BUS_ADDR_BITS-1:0] ADDR_DIV    = BUS_ADDR_BITS'(3);

    state_t     r_state;
    state_t     w_nextState;

    logic [7:0] r_cnt;
    logic [7:0] r_div;
    logic [6:0] r_tx;
    logic [7:0] r_rx;
    logic [7:0] r_data;
    logic [2:0] r_bit;
    logic       r_mosi;
    logic       r_done;
    logic       r_ovr;
    logic       r_ie;
    logic       r_cpha;
    logic       r_cpol;
    logic       r_ss;

    logic       w_busy;
    logic       w_wrData;
    logic       w_wrStatus;
    logic       w_wrCtrl;
    logic       w_wrDiv;
    logic       w_start;
    logic       w_halfDone;
    logic       w_leadEnd;
    logic       w_trailEnd;
    logic       w_lastBit;
    logic       w_finish;
    logic [7:0] w_rxShift;

    assign w_busy     = (r_state != IDLE);
    assign w_wrData   = cs && we && (addr == ADDR_DATA);
    assign w_wrStatus = cs && we && (addr == ADDR_STATUS);
    assign w_wrCtrl   = cs && we && (addr == ADDR_CTRL);
    assign w_wrDiv    = cs && we && (addr == ADDR_DIV);
    assign w_start    = w_wrData && !w_busy;
    // The counter runs 0..DIV, so every half-bit lasts DIV+1 cycles and
    // DIV=255 never needs a ninth counter bit.
    assign w_halfDone = (r_cnt == r_div);
    assign w_leadEnd  = (r_state == LEAD)  && w_halfDone;
    assign w_trailEnd = (r_state == TRAIL) && w_halfDone;
    assign w_lastBit  = (r_bit == 3'd7);
    assign w_finish   = w_trailEnd && w_lastBit;
    assign w_rxShift  = {r_rx[6:0], spi_miso};

    // State register of the shift engine; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: LEAD and TRAIL alternate once per half-period
    // until the eighth TRAIL ends.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start)    w_nextState = LEAD;
            LEAD:    if (w_halfDone) w_nextState = TRAIL;
            TRAIL:   if (w_halfDone) w_nextState = w_lastBit ? IDLE : LEAD;
            default: w_nextState = IDLE;
        endcase
    end

    // Pin outputs. SCK sits at cpol except during TRAIL, so its edges line
    // up exactly with the state transitions.
    always_comb begin
        spi_sck  = (r_state == TRAIL) ? ~r_cpol : r_cpol;
        spi_mosi = r_mosi;
        spi_cs_n = ~r_ss;
        irq_n    = ~(r_ie & r_done);
    end

    // Shift datapath. MOSI carries the current bit for a whole LEAD+TRAIL
    // pair and advances at TRAIL exit; r_tx keeps only the bits still to
    // come. MISO is sampled at LEAD exit for cpha=0, at TRAIL exit for cpha=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= 8'd0;
            r_bit  <= 3'd0;
            r_tx   <= 7'd0;
            r_rx   <= 8'd0;
            r_mosi <= 1'b0;
        end else begin
            if (r_state == IDLE || w_halfDone) begin
                r_cnt <= 8'd0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_start) begin
                r_tx   <= wr_data[6:0];
                r_mosi <= wr_data[7];
                r_bit  <= 3'd0;
                r_rx   <= 8'd0;
            end else begin
                if ((w_leadEnd && !r_cpha) || (w_trailEnd && r_cpha)) begin
                    r_rx <= w_rxShift;
                end
                if (w_trailEnd && !w_lastBit) begin
                    r_tx   <= {r_tx[5:0], 1'b0};
                    r_mosi <= r_tx[6];
                    r_bit  <= r_bit + 3'd1;
                end
            end
        end
    end

    // Software-visible registers. Completion setting done takes priority
    // over a simultaneous write-1-to-clear; mode and divider are frozen
    // while a transfer is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
            r_ie   <= 1'b0;
            r_cpha <= 1'b0;
            r_cpol <= 1'b0;
            r_ss   <= 1'b0;
            r_div  <= DIV_RESET;
            r_data <= 8'h00;
        end else begin
            if (w_finish) begin
                r_data <= r_cpha ? w_rxShift : r_rx;
            end

            if (w_finish) begin
                r_done <= 1'b1;
            end else if (w_start || (w_wrStatus && wr_data[6])) begin
                r_done <= 1'b0;
            end

            if (w_wrData && w_busy) begin
                r_ovr <= 1'b1;
            end else if (w_wrStatus && wr_data[5]) begin
                r_ovr <= 1'b0;
            end

            if (w_wrCtrl) begin
                r_ie <= wr_data[7];
                r_ss <= wr_data[0];
                if (!w_busy) begin
                    r_cpha <= wr_data[2];
                    r_cpol <= wr_data[1];
                end
            end

            if (w_wrDiv && !w_busy) begin
                r_div <= wr_data;
            end
        end
    end

    // Read mux; purely combinational so reads never disturb state.
    always_comb begin
        rd_data = 8'h00;
        if (cs) begin
            case (addr)
                ADDR_DATA:   rd_data = r_data;
                ADDR_STATUS: rd_data = {w_busy, r_done, r_ovr, 5'b00000};
                ADDR_CTRL:   rd_data = {r_ie, 4'b0000, r_cpha, r_cpol, r_ss};
                ADDR_DIV:    rd_data = r_div;
                default:     rd_data = 8'h00;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DIV_RESET, default 8'd3, reset value of the DIV register (SCK half-period = DIV+1 clk cycles).
REQ-002 SHALL have parameter BUS_ADDR_BITS, default 2, the width of the register select (fixed 4 registers).
REQ-003 Port clk  input  1  CPU clock; one clock domain, all logic on rising edge.
REQ-004 Port reset  input  1  reset; synchronous, active-high.
REQ-005 Port cs  input  1  chip select from the address decoder (window 0x7000–0x7003).
REQ-006 Port we  input  1  write strobe; a write occurs on a clk edge with cs=1 and we=1.
REQ-007 Port addr  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 DIV.
REQ-008 Port wr_data  input  8  write data.
REQ-009 Port rd_data  output  8  combinational read data for addr; 8'h00 when cs=0.
REQ-010 Port irq_n  output  1  active-low interrupt, wire-ANDed with other IRQ sources.
REQ-011 Port spi_sck, spi_mosi, spi_cs_n  output  1 each  SPI master pins.
REQ-012 Port spi_miso  input  1  SPI data in.

Function
REQ-013 Registers: DATA = tx on write, last rx byte on read; STATUS = {busy[7], done[6], ovr[5], 5'b0}; CTRL = {ie[7], 4'b0, cpha[2], cpol[1], ss[0]}; DIV = 8-bit divider.
REQ-014 Reads SHALL have no side effects.
REQ-015 Write to DATA with busy=0 SHALL load the shifter, set busy=1 next cycle, clear done, and start a transfer.
REQ-016 Write to DATA with busy=1 (including the completion cycle) SHALL be ignored, set ovr=1, and leave the transfer unaffected.
REQ-017 Write to STATUS: bit6=1 clears done, bit5=1 clears ovr (write-1-to-clear); other bits ignored.
REQ-018 Writes to CTRL cpol/cpha and to DIV while busy=1 SHALL be ignored; CTRL ie and ss are always writable.
REQ-019 spi_cs_n = ~ss, under software control only, never toggled by the engine.
REQ-020 FSM states: IDLE, LEAD (first half-bit), TRAIL (second half-bit); IDLE->LEAD on accepted DATA write; each state lasts DIV+1 cycles; LEAD->TRAIL; TRAIL->LEAD if bits remain, else ->IDLE.
REQ-021 spi_sck = cpol in IDLE and LEAD, ~cpol in TRAIL; the toggle SHALL occur exactly DIV+1 cycles after entering the state.
REQ-022 cpha=0: MOSI drives bit 7 from the first busy cycle, MISO sampled on the LEAD->TRAIL edge, shift on the TRAIL exit.
REQ-023 cpha=1: MOSI updates on LEAD entry, MISO sampled on the TRAIL->next edge.
REQ-024 Bits SHALL be sent MSB first; 8 bits per transfer; busy high for exactly 16*(DIV+1) cycles.
REQ-025 On the final TRAIL exit: rx byte latched into DATA, busy=0, done=1 in the same cycle.
REQ-026 spi_mosi SHALL hold its last bit while IDLE.
REQ-027 DIV SHALL be treated unsigned; DIV=255 gives a 256-cycle half-period with no wrap of the half-period counter.
REQ-028 irq_n = ~(ie & done), registered-free combinational from the flag registers.
REQ-029 If a STATUS done-clear write coincides with a completion, done SHALL end at 1 (set wins).

Reset
REQ-030 Reset SHALL force: IDLE, busy=0, done=0, ovr=0, ie=0, cpol=0, cpha=0, ss=0, DIV=DIV_RESET, rx DATA=8'h00.
REQ-031 Reset SHALL force outputs: spi_sck=0, spi_mosi=0, spi_cs_n=1, irq_n=1.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer on that edge: no done, rx byte discarded.

Verification
REQ-033 DIV=0, mode 0, MISO tied to MOSI, write DATA=8'hA5 -> busy exactly 16 cycles, 8 SCK rising edges, DATA reads 8'hA5, STATUS=8'h40.
REQ-034 DIV=3, cpol=1 cpha=1, MISO driven 8'h3C by a slave model -> busy 64 cycles, SCK idles high, DATA reads 8'h3C.
REQ-035 Write DATA=8'h11 then DATA=8'h22 two cycles later -> ovr=1, 8'h11 transmitted, 8'h22 never sent; STATUS write 8'h20 -> ovr=0.
REQ-036 ie=1, complete a transfer -> irq_n=0 the cycle after busy falls; STATUS write 8'h40 -> irq_n=1.
REQ-037 Reset at cycle 5 of a DIV=1 transfer -> next cycle all REQ-030/031 values, done=0, DIV=DIV_RESET.
REQ-038 DIV write of 8'h07 while busy -> DIV unchanged; the same write after busy=0 -> DIV reads 8'h07.
